flops_lane_arbiter: RTL and testbench

//  Two-lane round-robin arbiter and buffer in front of the 32-bit flop/recirculation stage, clocked by clk_2f.

---
 rtl/flops_lane_arbiter.sv | 103 ++++++++++
 tb/tb_flops_lane_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/flops_lane_arbiter.sv
// flops_lane_arbiter: two-lane round-robin FIFO arbiter with a registered, recirculating output word
module flops_lane_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 2
) (
  input  logic                          clk_2f,
  input  logic                          reset_L,
  input  logic                          valid_0,
  input  logic [DATA_W-1:0]             data_0,
  output logic                          ready_0,
  input  logic                          valid_1,
  input  logic [DATA_W-1:0]             data_1,
  output logic                          ready_1,
  input  logic                          ready_down,
  output logic                          valid_out_arb,
  output logic [DATA_W-1:0]             data_out_arb,
  output logic                          lane_out_arb,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_0,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_1
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t              r_state;
  logic                r_last_lane;
  logic [BW-1:0]       r_burst;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic                r_lane;
  logic [DATA_W-1:0]   r_mem [2][FIFO_DEPTH];
  logic [AW-1:0]       r_wp [2];
  logic [AW-1:0]       r_rp [2];
  logic [CW-1:0]       r_cnt [2];
  logic [DATA_W-1:0]   w_din [2];
  logic [DATA_W-1:0]   w_head [2];
  logic [1:0]          w_push, w_pop, w_ne;
  logic                w_load, w_gl, w_other_ne, w_empty_next;
  assign ready_0       = r_cnt[0] != CW'(FIFO_DEPTH);
  assign ready_1       = r_cnt[1] != CW'(FIFO_DEPTH);
  assign w_din[0]      = data_0;
  assign w_din[1]      = data_1;
  assign w_head[0]     = r_mem[0][r_rp[0]];
  assign w_head[1]     = r_mem[1][r_rp[1]];
  assign w_push        = {valid_1 & ready_1, valid_0 & ready_0};
  assign w_ne          = {r_cnt[1] != '0, r_cnt[0] != '0};
  assign w_load        = (!r_valid || ready_down) && r_state != IDLE;
  assign w_gl          = r_state == GNT1;
  assign w_pop         = {w_load & w_gl, w_load & (r_state == GNT0)};
  assign w_other_ne    = w_ne[!w_gl];
  // the granted FIFO drains on this pop unless a push refills it on the same edge
  assign w_empty_next  = r_cnt[w_gl] == CW'(1) && !w_push[w_gl];
  assign valid_out_arb = r_valid;
  assign data_out_arb  = r_data;
  assign lane_out_arb  = r_lane;
  assign fifo_cnt_0    = r_cnt[0];
  assign fifo_cnt_1    = r_cnt[1];
  always_ff @(posedge clk_2f)
    for (int i = 0; i < 2; i++)
      if (w_push[i]) r_mem[i][r_wp[i]] <= w_din[i];
  always_ff @(posedge clk_2f or negedge reset_L)
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
        if (w_pop[i]) r_rp[i] <= r_rp[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
    end
  always_ff @(posedge clk_2f or negedge reset_L)
    if (!reset_L) begin
      r_state     <= IDLE;
      r_last_lane <= 1'b1;
      r_burst     <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_lane      <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_head[w_gl];
        r_lane  <= w_gl;
      end else if (ready_down) r_valid <= 1'b0;
      if (r_state == IDLE)
        r_state <= &w_ne ? (r_last_lane ? GNT0 : GNT1) : w_ne[0] ? GNT0 : w_ne[1] ? GNT1 : IDLE;
      else if (w_load) begin
        r_last_lane <= w_gl;
        if (w_empty_next) begin
          r_state <= w_other_ne ? (w_gl ? GNT0 : GNT1) : IDLE;
          r_burst <= '0;
        end else if (r_burst == BW'(MAX_BURST - 1) && w_other_ne) begin
          r_state <= w_gl ? GNT0 : GNT1;
          r_burst <= '0;
        end else if (r_burst != BW'(MAX_BURST - 1)) r_burst <= r_burst + 1'b1;
      end
    end
endmodule

// File: tb/tb_flops_lane_arbiter.sv
// tb_flops_lane_arbiter: per-lane scoreboard plus directed arbitration, stall, full, wrap and reset checks
module tb_flops_lane_arbiter;
  localparam int D = 4;
  logic        clk_2f = 0, reset_L = 1, valid_0 = 0, valid_1 = 0, ready_down = 0;
  logic [31:0] data_0 = 0, data_1 = 0;
  logic        ready_0, ready_1, valid_out_arb, lane_out_arb;
  logic [31:0] data_out_arb;
  logic [2:0]  fifo_cnt_0, fifo_cnt_1;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] q0[$], q1[$];
  flops_lane_arbiter #(.DATA_W(32), .FIFO_DEPTH(D), .MAX_BURST(2)) dut (
    .clk_2f(clk_2f), .reset_L(reset_L),
    .valid_0(valid_0), .data_0(data_0), .ready_0(ready_0),
    .valid_1(valid_1), .data_1(data_1), .ready_1(ready_1),
    .ready_down(ready_down), .valid_out_arb(valid_out_arb),
    .data_out_arb(data_out_arb), .lane_out_arb(lane_out_arb),
    .fifo_cnt_0(fifo_cnt_0), .fifo_cnt_1(fifo_cnt_1));
  always #5 clk_2f = ~clk_2f;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask
  // accepted pushes are queued per lane; every word taken downstream must be its lane's oldest
  task automatic monitor();
    forever begin
      @(negedge clk_2f);
      if (!reset_L) begin
        q0.delete();
        q1.delete();
      end else begin
        if (valid_0 && ready_0) q0.push_back(data_0);
        if (valid_1 && ready_1) q1.push_back(data_1);
        if (valid_out_arb && ready_down) begin
          if ((lane_out_arb ? q1.size() : q0.size()) == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL word_lane%0d: got %h expected nothing queued", lane_out_arb, data_out_arb);
          end else if (lane_out_arb) chk("word_lane1", data_out_arb, q1.pop_front());
          else chk("word_lane0", data_out_arb, q0.pop_front());
        end
      end
    end
  endtask
  task automatic push(input bit lane, input logic [31:0] d);
    if (lane) begin valid_1 = 1; data_1 = d; end
    else begin valid_0 = 1; data_0 = d; end
    tick();
    valid_0 = 0;
    valid_1 = 0;
  endtask
  task automatic wait_valid();
    int t = 0;
    while (!valid_out_arb && t < 20) begin tick(); t++; end
    chk("wait_valid_timeout", 32'(t < 20), 1);
  endtask
  task automatic drain();
    int t = 0;
    valid_0 = 0;
    valid_1 = 0;
    ready_down = 1;
    while ((valid_out_arb || fifo_cnt_0 != 0 || fifo_cnt_1 != 0) && t < 100) begin tick(); t++; end
    chk("drain_timeout", 32'(t < 100), 1);
    chk("queues_empty", q0.size() + q1.size(), 0);
  endtask
  task automatic do_reset();
    reset_L = 0;
    tick();
    tick();
    reset_L = 1;
  endtask
  initial begin
    bit exp_lane [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    fork monitor(); join_none
    #2 reset_L = 0;
    repeat (4) begin
      valid_0 = 1'($urandom); valid_1 = 1'($urandom); ready_down = 1'($urandom);
      data_0 = $urandom; data_1 = $urandom;
      tick();
    end
    chk("rst_valid", valid_out_arb, 0);
    chk("rst_data", data_out_arb, 0);
    chk("rst_lane", lane_out_arb, 0);
    chk("rst_ready0", ready_0, 1);
    chk("rst_ready1", ready_1, 1);
    chk("rst_cnt0", fifo_cnt_0, 0);
    chk("rst_cnt1", fifo_cnt_1, 0);
    valid_0 = 0; valid_1 = 0; ready_down = 1;
    reset_L = 1;
    tick();
    push(0, 32'hA5A5_0001);
    chk("lat_edge_k", valid_out_arb, 0);
    tick();
    chk("lat_edge_k1", valid_out_arb, 0);
    tick();
    chk("lat_valid", valid_out_arb, 1);
    chk("lat_data", data_out_arb, 32'hA5A5_0001);
    chk("lat_lane", lane_out_arb, 0);
    drain();
    // fairness: both lanes prefilled behind a stalled output
    do_reset();
    ready_down = 0;
    for (int i = 0; i < 4; i++) begin
      valid_0 = 1; valid_1 = 1; data_0 = 32'h2000_0000 + i; data_1 = 32'h2100_0000 + i;
      tick();
    end
    valid_0 = 0; valid_1 = 0; ready_down = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_2f);
      chk($sformatf("fair_valid%0d", i), valid_out_arb, 1);
      chk($sformatf("fair_lane%0d", i), lane_out_arb, exp_lane[i]);
    end
    tick();
    drain();
    // stall: output recirculates while lane 1 fills behind it
    ready_down = 0;
    push(0, 32'hDEAD_BEEF);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      valid_1 = 1; data_1 = 32'h3000_0000 + i;
      tick();
      chk("stall_valid", valid_out_arb, 1);
      chk("stall_data", data_out_arb, 32'hDEAD_BEEF);
      chk("stall_lane", lane_out_arb, 0);
    end
    valid_1 = 0;
    chk("stall_ready1", ready_1, 0);
    chk("stall_cnt1", fifo_cnt_1, D);
    ready_down = 1;
    tick();
    chk("stall_next_valid", valid_out_arb, 1);
    chk("stall_next_lane", lane_out_arb, 1);
    chk("stall_next_data", data_out_arb, 32'h3000_0000);
    drain();
    // full and wrap: three fill/drain passes of lane 1 with two overflow words each
    for (int p = 0; p < 3; p++) begin
      ready_down = 0;
      push(0, 32'h4000_0000 + p);
      wait_valid();
      for (int i = 0; i < 6; i++) begin
        valid_1 = 1; data_1 = 32'h5000_0000 + p * 16 + i;
        tick();
      end
      valid_1 = 0;
      chk("full_cnt1", fifo_cnt_1, D);
      chk("full_ready1", ready_1, 0);
      drain();
    end
    // simultaneous push and pop on lane 0 at count 2
    ready_down = 0;
    for (int i = 0; i < 3; i++) begin
      valid_0 = 1; data_0 = 32'h6000_0000 + i;
      tick();
    end
    chk("simul_pre_cnt0", fifo_cnt_0, 2);
    chk("simul_pre_valid", valid_out_arb, 1);
    data_0 = 32'h6000_0003; ready_down = 1;
    tick();
    valid_0 = 0;
    chk("simul_cnt0", fifo_cnt_0, 2);
    drain();
    // asynchronous reset in the middle of a lane 1 grant
    ready_down = 0;
    push(1, 32'h7000_0000);
    push(1, 32'h7000_0001);
    wait_valid();
    #3 reset_L = 0;
    #1;
    chk("arst_valid", valid_out_arb, 0);
    chk("arst_cnt1", fifo_cnt_1, 0);
    chk("arst_ready1", ready_1, 1);
    @(negedge clk_2f);
    tick();
    reset_L = 1;
    valid_0 = 1; valid_1 = 1; data_0 = 32'h8000_0000; data_1 = 32'h8100_0000;
    tick();
    valid_0 = 0; valid_1 = 0; ready_down = 1;
    wait_valid();
    chk("arst_first_lane", lane_out_arb, 0);
    chk("arst_first_data", data_out_arb, 32'h8000_0000);
    drain();
    // random traffic against the per-lane scoreboard
    for (int i = 0; i < 400; i++) begin
      valid_0 = ($urandom % 3) != 0;
      valid_1 = ($urandom % 3) != 0;
      data_0 = $urandom; data_1 = $urandom;
      ready_down = ($urandom % 4) != 0;
      tick();
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
